// File: rtl/bp_pkg.sv
// Shared opcode, jump-select and counter definitions for the gshare branch predictor.
// Pure declarations: no timing or flow control of its own.
package bp_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  localparam logic [1:0] JSEL_SEQ = 2'b00;
  localparam logic [1:0] JSEL_J   = 2'b01;
  localparam logic [1:0] JSEL_JR  = 2'b10;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  // Saturating 2-bit counter step; holds at either end rather than wrapping.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken && (c != STRONG_T)) begin
      n = ctr_e'(c + 2'd1);
    end else if (!taken && (c != STRONG_NT)) begin
      n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Table of 2-bit saturating counters: async read, one saturating write per clock.
// Read is 0-cycle with no bypass of a same-cycle write; never backpressures.
module bht
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output ctr_e                   rd_ctr_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic                   wr_taken_i
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  ctr_e ctr_q [DEPTH];
  ctr_e ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en_i) begin
      ctr_d[wr_idx_i] = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= WEAK_NT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Gshare next-PC predictor: combinational F-stage prediction, D-side record, miss flag.
// Prediction 0 cycles; D record held by stall_d_i, killed by flush_d_i; no self-flush.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int HIST_WIDTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_f_i,
  input  logic [31:0] instr_f_i,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        pc_src_d_i,
  input  logic [2:0]  jump_d_i,
  output logic [31:0] predict_pc_o,
  output logic        predict_miss_o
);

  logic [5:0]             opcode_f;
  logic                   is_branch_f;
  logic                   is_jump_f;
  logic                   pred_taken_f;
  logic [31:0]            pc4_f;
  logic [31:0]            btarget_f;
  logic [31:0]            jtarget_f;
  logic [INDEX_WIDTH-1:0] idx_f;
  ctr_e                   ctr_f;

  logic [HIST_WIDTH-1:0]  ghr_q, ghr_d;
  logic                   valid_q, valid_d;
  logic                   is_branch_q, is_branch_d;
  logic                   pred_taken_q, pred_taken_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   update;

  // Fetch stall only matters through pc_f_i being held upstream.
  logic unused_ok;
  assign unused_ok = ^{stall_f_i, jump_d_i[2]};

  assign opcode_f    = instr_f_i[31:26];
  assign is_branch_f = (opcode_f == OP_BEQ) || (opcode_f == OP_BNE);
  assign is_jump_f   = (opcode_f == OP_J) || (opcode_f == OP_JAL);
  assign idx_f       = pc_f_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign pc4_f       = pc_f_i + 32'd4;
  assign btarget_f   = pc4_f + {{14{instr_f_i[15]}}, instr_f_i[15:0], 2'b00};
  assign jtarget_f   = {pc4_f[31:28], instr_f_i[25:0], 2'b00};
  assign pred_taken_f = is_branch_f & ctr_f[1];

  bht #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (idx_f),
    .rd_ctr_o   (ctr_f),
    .wr_en_i    (update),
    .wr_idx_i   (idx_q),
    .wr_taken_i (pc_src_d_i)
  );

  always_comb begin
    predict_pc_o = pc4_f;
    if (is_jump_f) begin
      predict_pc_o = jtarget_f;
    end else if (pred_taken_f) begin
      predict_pc_o = btarget_f;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    is_branch_d  = is_branch_q;
    pred_taken_d = pred_taken_q;
    idx_d        = idx_q;
    if (flush_d_i) begin
      valid_d = 1'b0;
    end else if (!stall_d_i) begin
      valid_d      = 1'b1;
      is_branch_d  = is_branch_f;
      pred_taken_d = pred_taken_f;
      idx_d        = idx_f;
    end
  end

  // jr is always predicted as pc4, so resolving one in D is a guaranteed miss.
  assign predict_miss_o = valid_q & ~stall_d_i &
                          ((is_branch_q & (pc_src_d_i != pred_taken_q)) |
                           (jump_d_i[1:0] == JSEL_JR));

  assign update = valid_q & is_branch_q & ~stall_d_i;

  always_comb begin
    ghr_d = ghr_q;
    if (update) begin
      ghr_d = {ghr_q[HIST_WIDTH-2:0], pc_src_d_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      valid_q      <= 1'b0;
      is_branch_q  <= 1'b0;
      pred_taken_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      ghr_q        <= ghr_d;
      valid_q      <= valid_d;
      is_branch_q  <= is_branch_d;
      pred_taken_q <= pred_taken_d;
      idx_q        <= idx_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for F-side prediction,
// hand sequences for miss, stall, flush, saturation and async reset.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] JR_RA = 32'h03E0_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f_i;
  logic [31:0] instr_f_i;
  logic        stall_f_i;
  logic        stall_d_i;
  logic        flush_d_i;
  logic        pc_src_d_i;
  logic [2:0]  jump_d_i;
  logic [31:0] predict_pc_o;
  logic        predict_miss_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .INDEX_WIDTH(6),
    .HIST_WIDTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_f_i        (pc_f_i),
    .instr_f_i     (instr_f_i),
    .stall_f_i     (stall_f_i),
    .stall_d_i     (stall_d_i),
    .flush_d_i     (flush_d_i),
    .pc_src_d_i    (pc_src_d_i),
    .jump_d_i      (jump_d_i),
    .predict_pc_o  (predict_pc_o),
    .predict_miss_o(predict_miss_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic        exp_miss;
  } sat_t;

  vec_t vecs [9];
  sat_t sats [4];

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {OP_BEQ, 10'd0, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic stall,
                       input logic flush, input logic src, input logic [1:0] jsel);
    pc_f_i     = pc;
    instr_f_i  = ins;
    stall_d_i  = stall;
    flush_d_i  = flush;
    pc_src_d_i = src;
    jump_d_i   = {1'b0, jsel};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // All counters weakly not-taken, ghr 0: branches predict pc4.
    vecs[0] = '{32'h0040_0000, beq(16'h0004),            32'h0040_0004};
    vecs[1] = '{32'h0040_0020, {OP_J, 26'h010_0010},     32'h0040_0040};
    vecs[2] = '{32'hF000_0000, {OP_JAL, 26'h3FF_FFFF},   32'hFFFF_FFFC};
    vecs[3] = '{32'h0040_0100, {OP_BNE, 10'd0, 16'hFFFF}, 32'h0040_0104};
    vecs[4] = '{32'h0040_0008, 32'h0000_0020,            32'h0040_000C};
    vecs[5] = '{32'hFFFF_FFFC, NOP,                      32'h0000_0000};
    vecs[6] = '{32'h0040_0010, JR_RA,                    32'h0040_0014};
    vecs[7] = '{32'h0000_1000, 32'h8C00_0000,            32'h0000_1004};
    vecs[8] = '{32'h1FFF_FFFC, {OP_J, 26'h000_0000},     32'h2000_0000};

    // Four taken resolutions aimed at index 0x30 as ghr walks 6->D->B->7->F.
    sats[0] = '{32'h0040_00D8, 32'h0040_00DC, 1'b1};
    sats[1] = '{32'h0040_00F4, 32'h0040_0108, 1'b0};
    sats[2] = '{32'h0040_00EC, 32'h0040_0100, 1'b0};
    sats[3] = '{32'h0040_00DC, 32'h0040_00F0, 1'b0};

    stall_f_i = 1'b0;
    rst = 1'b1;
    drive(32'h0040_0000, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_JR);
    chk("reset_miss", {31'd0, predict_miss_o}, 32'd0);
    chk("reset_pred", predict_pc_o, 32'h0040_0004);
    #10;
    rst = 1'b0;
    #1;
    chk("reset_d_invalid", {31'd0, predict_miss_o}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pc, vecs[i].instr, 1'b1, 1'b0, 1'b0, JSEL_SEQ);
      chk($sformatf("vec%0d_pred", i), predict_pc_o, vecs[i].exp_pc);
      chk($sformatf("vec%0d_miss", i), {31'd0, predict_miss_o}, 32'd0);
    end

    // beq resolved taken: miss, counter[0] 01->10, ghr 0001.
    tick();
    drive(32'h0040_0000, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("beq_f_pred", predict_pc_o, 32'h0040_0004);
    tick();
    drive(32'h0040_0004, NOP, 1'b0, 1'b0, 1'b1, JSEL_SEQ);
    chk("beq_taken_miss", {31'd0, predict_miss_o}, 32'd1);
    tick();
    drive(32'h0040_0000, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("ghr_reindex", predict_pc_o, 32'h0040_0004);
    drive(32'h0040_0004, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("ctr_taken_visible", predict_pc_o, 32'h0040_0018);

    // j predicted exactly, jr always misses.
    drive(32'h0040_0020, {OP_J, 26'h010_0010}, 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("j_pred", predict_pc_o, 32'h0040_0040);
    tick();
    drive(32'h0040_0040, JR_RA, 1'b0, 1'b0, 1'b0, JSEL_J);
    chk("j_no_miss", {31'd0, predict_miss_o}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0040_0040, JR_RA, 1'b0, 1'b0, 1'b0, JSEL_JR);
      chk($sformatf("jr_miss%0d", i), {31'd0, predict_miss_o}, 32'd1);
      tick();
    end

    // Branch held in D for 3 stalled cycles, then released taken.
    drive(32'h0040_0040, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("stall_beq_pred", predict_pc_o, 32'h0040_0044);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0040_0044, NOP, 1'b1, 1'b0, 1'b1, JSEL_SEQ);
      chk($sformatf("stall_hold%0d", i), {31'd0, predict_miss_o}, 32'd0);
      tick();
    end
    drive(32'h0040_0044, NOP, 1'b0, 1'b0, 1'b1, JSEL_SEQ);
    chk("stall_release_miss", {31'd0, predict_miss_o}, 32'd1);
    tick();
    drive(32'h0040_0048, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("ghr_shift_once", predict_pc_o, 32'h0040_005C);
    drive(32'h0040_0048, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    tick();
    drive(32'h0040_004C, NOP, 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("pred_t_resolved_nt", {31'd0, predict_miss_o}, 32'd1);
    tick();
    drive(32'h0040_005C, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("single_update", predict_pc_o, 32'h0040_0060);

    // Flush wins over stall and suppresses both miss and update.
    drive(32'h0040_0080, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    tick();
    drive(32'h0040_0084, NOP, 1'b1, 1'b1, 1'b1, JSEL_SEQ);
    tick();
    drive(32'h0040_0084, NOP, 1'b0, 1'b0, 1'b1, JSEL_SEQ);
    chk("flush_no_miss", {31'd0, predict_miss_o}, 32'd0);
    tick();
    drive(32'h0040_0080, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("flush_no_update", predict_pc_o, 32'h0040_0084);

    for (int i = 0; i < 4; i++) begin
      drive(sats[i].pc, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
      chk($sformatf("sat%0d_pred", i), predict_pc_o, sats[i].exp_pc);
      tick();
      drive(sats[i].pc + 32'd4, NOP, 1'b0, 1'b0, 1'b1, JSEL_SEQ);
      chk($sformatf("sat%0d_miss", i), {31'd0, predict_miss_o}, {31'd0, sats[i].exp_miss});
      tick();
    end
    drive(32'h0040_00FC, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("sat_hold_taken", predict_pc_o, 32'h0040_0110);
    drive(32'h0040_00FC, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    tick();
    drive(32'h0040_0100, NOP, 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("sat_nt_miss", {31'd0, predict_miss_o}, 32'd1);
    tick();
    drive(32'h0040_00F8, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("sat_no_wrap", predict_pc_o, 32'h0040_010C);

    // Async reset mid-cycle with a pending miss in D.
    drive(32'h0040_00F8, beq(16'h0004), 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    tick();
    drive(32'h0040_00FC, NOP, 1'b0, 1'b0, 1'b0, JSEL_SEQ);
    chk("pre_reset_miss", {31'd0, predict_miss_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_async_miss", {31'd0, predict_miss_o}, 32'd0);
    drive(32'h0040_00C0, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("reset_table", predict_pc_o, 32'h0040_00C4);
    drive(32'h0040_00FC, beq(16'h0004), 1'b1, 1'b0, 1'b0, JSEL_SEQ);
    chk("reset_ghr", predict_pc_o, 32'h0040_0100);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
